// File: rtl/zld_xc_if.sv
`default_nettype none
// ============================================================================
// Module      : zld_xc_if
// Description : Token-in / word-out stream bundle for the zero run-length
//               decoder. The slave side is the decoder itself; the master
//               side is the surrounding environment (upstream token source
//               and downstream word sink).
// Revision    : 1.0 - initial release
// ============================================================================
interface zld_xc_if #(
    parameter int WI = 3,
    parameter int WO = 2
);
    logic [WI-1:0] i_d;
    logic          i_v;
    logic          i_b;
    logic [WO-1:0] o_d;
    logic          o_v;
    logic          o_b;

    modport slave (
        input  i_d,
        input  i_v,
        input  o_b,
        output i_b,
        output o_d,
        output o_v
    );

    modport master (
        output i_d,
        output i_v,
        output o_b,
        input  i_b,
        input  o_d,
        input  o_v
    );
endinterface
`default_nettype wire

// File: rtl/zld_xc.sv
`default_nettype none
// ============================================================================
// Module      : zld_xc
// Description : Zero run-length decoder. Each token is either a literal word
//               (MSB=0) or a run of field+1 zero words (MSB=1). Output is a
//               single registered word slot with valid/backpressure flow
//               control; upstream is held off while a run is expanding.
// Revision    : 1.0 - initial release
// ============================================================================
module zld_xc #(
    parameter int WI = 3,
    parameter int WO = 2
) (
    input  logic   clock,
    input  logic   reset,
    zld_xc_if.slave bus
);

    logic [WO-1:0] out_d;
    logic          out_v;
    logic [WO-1:0] run_cnt;     // zeros still owed after the word in out_d
    logic          run_act;     // run expansion in progress

    logic          slot_free;
    logic          in_busy;
    logic          accept;
    logic          tok_run;
    logic [WO-1:0] tok_field;

    // Token decode and handshake: the slot can take a new word when it is
    // empty or its current word leaves this cycle. Backpressure depends only
    // on registers and o_b so it never loops back through i_v/i_d.
    always_comb begin
        slot_free = !out_v || !bus.o_b;
        in_busy   = run_act || !slot_free;
        accept    = bus.i_v && !in_busy;
        tok_run   = bus.i_d[WI-1];
        tok_field = bus.i_d[WO-1:0];
    end

    assign bus.i_b = in_busy;
    assign bus.o_d = out_d;
    assign bus.o_v = out_v;

    // Output slot and run expansion, in priority order: owed zeros first,
    // then a freshly accepted token, otherwise drain or hold.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_d   <= '0;
            out_v   <= 1'b0;
            run_cnt <= '0;
            run_act <= 1'b0;
        end else if (run_act && slot_free) begin
            // run_act is cleared as run_cnt reaches zero, so it never wraps
            out_d   <= '0;
            out_v   <= 1'b1;
            run_cnt <= run_cnt - WO'(1);
            run_act <= (run_cnt != WO'(1));
        end else if (accept && !tok_run) begin
            out_d   <= tok_field;
            out_v   <= 1'b1;
        end else if (accept) begin
            // first zero of the run loads now; the field counts the rest
            out_d   <= '0;
            out_v   <= 1'b1;
            run_cnt <= tok_field;
            run_act <= (tok_field != '0);
        end else if (slot_free) begin
            out_v   <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_zld_xc.sv
`default_nettype none
// ============================================================================
// Module      : tb_zld_xc
// Description : Self-checking bench for zld_xc: directed vector table,
//               reset sequences, and randomized traffic against a
//               word-queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zld_xc;
    localparam int WI = 3;
    localparam int WO = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    zld_xc_if #(.WI(WI), .WO(WO)) bus ();
    zld_xc #(.WI(WI), .WO(WO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Directed vector: inputs for one cycle and the outputs expected
    // between the edges of that same cycle.
    typedef struct {
        logic       iv;
        logic [2:0] d;
        logic       ob;
        logic       ev;
        logic [1:0] ed;
        logic       eib;
    } vec_t;

    function automatic vec_t mk(logic iv, logic [2:0] d, logic ob,
                                logic ev, logic [1:0] ed, logic eib);
        vec_t r;
        r.iv = iv; r.d = d; r.ob = ob; r.ev = ev; r.ed = ed; r.eib = eib;
        return r;
    endfunction

    vec_t vecs[26];

    // Reference model: the output slot plus a queue of words already owed
    // by an accepted token but not yet loaded into the slot.
    logic       m_full;
    logic [1:0] m_d;
    logic [1:0] owed[$];
    int         n_exp_words;
    int         n_out_words;

    task automatic model_cycle(input string tag);
        logic exp_ib;
        logic slot_free;
        logic [1:0] fld;
        @(negedge clock);
        exp_ib = (owed.size() != 0) || (m_full && bus.o_b);
        chk({tag, "_o_v"}, 32'(bus.o_v), 32'(m_full));
        chk({tag, "_o_d"}, 32'(bus.o_d), 32'(m_d));
        chk({tag, "_i_b"}, 32'(bus.i_b), 32'(exp_ib));
        if (bus.o_v && !bus.o_b) n_out_words++;
        slot_free = !m_full || !bus.o_b;
        if (slot_free) begin
            if (owed.size() != 0) begin
                m_d    = owed.pop_front();
                m_full = 1'b1;
            end else if (bus.i_v) begin
                fld = bus.i_d[1:0];
                if (!bus.i_d[2]) owed.push_back(fld);
                else for (int k = 0; k <= int'(fld); k++) owed.push_back(2'd0);
                n_exp_words += owed.size();
                m_d    = owed.pop_front();
                m_full = 1'b1;
            end else begin
                m_full = 1'b0;
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        // literals, back-to-back
        vecs[0]  = mk(1, 3'b001, 0, 0, 2'd0, 0);
        vecs[1]  = mk(1, 3'b011, 0, 1, 2'd1, 0);
        vecs[2]  = mk(1, 3'b000, 0, 1, 2'd3, 0);
        vecs[3]  = mk(1, 3'b010, 0, 1, 2'd0, 0);
        // runs: 1 zero, 4 zeros, then literal 1 held back until run ends
        vecs[4]  = mk(1, 3'b100, 0, 1, 2'd2, 0);
        vecs[5]  = mk(1, 3'b111, 0, 1, 2'd0, 0);
        vecs[6]  = mk(1, 3'b001, 0, 1, 2'd0, 1);
        vecs[7]  = mk(1, 3'b001, 0, 1, 2'd0, 1);
        vecs[8]  = mk(1, 3'b001, 0, 1, 2'd0, 1);
        vecs[9]  = mk(1, 3'b001, 0, 1, 2'd0, 0);
        vecs[10] = mk(0, 3'b000, 0, 1, 2'd1, 0);
        vecs[11] = mk(0, 3'b000, 0, 0, 2'd1, 0);
        // 3-zero run under o_b = 1,0,1,1,0,0
        vecs[12] = mk(1, 3'b110, 1, 0, 2'd1, 0);
        vecs[13] = mk(0, 3'b000, 1, 1, 2'd0, 1);
        vecs[14] = mk(0, 3'b000, 0, 1, 2'd0, 1);
        vecs[15] = mk(0, 3'b000, 1, 1, 2'd0, 1);
        vecs[16] = mk(0, 3'b000, 1, 1, 2'd0, 1);
        vecs[17] = mk(0, 3'b000, 0, 1, 2'd0, 1);
        vecs[18] = mk(0, 3'b000, 0, 1, 2'd0, 0);
        vecs[19] = mk(0, 3'b000, 0, 0, 2'd0, 0);
        // idle gaps: a literal every third cycle
        vecs[20] = mk(1, 3'b011, 0, 0, 2'd0, 0);
        vecs[21] = mk(0, 3'b000, 0, 1, 2'd3, 0);
        vecs[22] = mk(0, 3'b000, 0, 0, 2'd3, 0);
        vecs[23] = mk(1, 3'b010, 0, 0, 2'd3, 0);
        vecs[24] = mk(0, 3'b000, 0, 1, 2'd2, 0);
        vecs[25] = mk(0, 3'b000, 0, 0, 2'd2, 0);

        // reset held with a valid token present
        bus.i_v = 1'b1;
        bus.i_d = 3'b101;
        bus.o_b = 1'b0;
        repeat (3) begin
            @(negedge clock);
            chk("rst_hold_o_v", 32'(bus.o_v), 0);
            chk("rst_hold_o_d", 32'(bus.o_d), 0);
            chk("rst_hold_i_b", 32'(bus.i_b), 0);
        end
        @(posedge clock);
        #1 reset = 1'b1;
        #1 chk("rst_release_o_v", 32'(bus.o_v), 0);

        // directed table
        for (int i = 0; i < 26; i++) begin
            bus.i_v = vecs[i].iv;
            bus.i_d = vecs[i].d;
            bus.o_b = vecs[i].ob;
            @(negedge clock);
            chk($sformatf("vec%0d_o_v", i), 32'(bus.o_v), 32'(vecs[i].ev));
            chk($sformatf("vec%0d_o_d", i), 32'(bus.o_d), 32'(vecs[i].ed));
            chk($sformatf("vec%0d_i_b", i), 32'(bus.i_b), 32'(vecs[i].eib));
            @(posedge clock);
            #1;
        end

        // asynchronous reset in the middle of a 3-zero run
        bus.i_v = 1'b1;
        bus.i_d = 3'b110;
        bus.o_b = 1'b0;
        @(posedge clock);
        #1 bus.i_v = 1'b0;
        @(negedge clock);
        chk("midrun_first_o_v", 32'(bus.o_v), 1);
        chk("midrun_first_i_b", 32'(bus.i_b), 1);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        chk("midrun_rst_o_v", 32'(bus.o_v), 0);
        chk("midrun_rst_o_d", 32'(bus.o_d), 0);
        chk("midrun_rst_i_b", 32'(bus.i_b), 0);
        @(posedge clock);
        #1 reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            chk("midrun_after_o_v", 32'(bus.o_v), 0);
            chk("midrun_after_i_b", 32'(bus.i_b), 0);
            @(posedge clock);
            #1;
        end

        // randomized traffic against the reference model
        m_full      = 1'b0;
        m_d         = 2'd0;
        owed.delete();
        n_exp_words = 0;
        n_out_words = 0;
        for (int c = 0; c < 3000; c++) begin
            bus.i_v = ($urandom_range(99) < 70);
            if ($urandom_range(99) < 40)
                bus.i_d = {1'b1, 2'($urandom_range(3))};
            else if ($urandom_range(99) < 50)
                bus.i_d = 3'b000;
            else
                bus.i_d = {1'b0, 2'($urandom_range(3))};
            bus.o_b = ($urandom_range(99) < 30);
            model_cycle("rand");
        end
        bus.i_v = 1'b0;
        bus.o_b = 1'b0;
        for (int c = 0; c < 10; c++) model_cycle("drain");
        chk("drain_owed_empty", 32'(owed.size()), 0);
        chk("word_count", 32'(n_out_words), 32'(n_exp_words));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
